hci_core_pipe_slice: RTL and testbench
======================================

// Module: hci_core_pipe_slice
// PURPOSE
// Parametrised, registered successor to the plain HCI core pass-through wire.
// Sits between an hci_core_intf initiator and target to break timing paths.
// Request and response directions are each independently either a 2-entry skid
// buffer (registered, full throughput, no combinational gnt/lrdy path) or a
// combinational pass-through. Transaction order is preserved in both directions.
// PARAMETERS
// DW       32  data width of data / r_data
// AW       32  address width of add
// BW       8   byte width; be width = DW/BW
// UW       1   user width of user / r_user
// REQ_CUT  1   1: request path uses a skid buffer; 0: request path is combinational pass-through
// RSP_CUT  1   1: response path uses a skid buffer; 0: response path is combinational pass-through
// PORTS
// clk_i                 in   1     clock
// clear_i               in   1     reset, synchronous, active-high
// tcdm_slave            intf -     hci_core_intf.slave (req/gnt/add/wen/data/be/boffs/lrdy/user in; r_* out)
// tcdm_master           intf -     hci_core_intf.master (mirror of tcdm_slave)
// idle_o                out  1     both buffers empty
// rsp_overflow_o        out  1     sticky: a response arrived while the response buffer was full
// BEHAVIOUR
// - Request payload = {add, wen, data, be, boffs, user}; response payload = {r_data, r_opc, r_user}.
// - Each cut path has one 2-entry skid buffer, in_valid/in_ready -> out_valid/out_ready, states:
//   EMPTY (0 entries), ONE (1 entry), TWO (2 entries).
// - in_ready is a registered signal = (state != TWO); out_valid = (state != EMPTY); the head entry drives the output.
// - Push = in_valid & in_ready; pop = out_valid & out_ready. Next state:
//   EMPTY->ONE on push; ONE->TWO on push&!pop; ONE->EMPTY on pop&!push;
//   ONE stays ONE on push&pop (new entry becomes head next cycle);
//   TWO->ONE on pop (push impossible). Anything else holds state.
// - Request map: in_valid = slave.req, slave.gnt = in_ready, master.req = out_valid, out_ready = master.gnt.
// - Response map: in_valid = master.r_valid, master.lrdy = in_ready, slave.r_valid = out_valid,
//   out_ready = slave.lrdy.
// - Latency with cut: one cycle per direction. A push at edge N is visible on the output in cycle N+1.
// - Throughput: one transaction per cycle sustained when the output never stalls.
// - The output is stable while stalled: master.req and payload hold until master.gnt (likewise r_valid until lrdy).
// - Cut = 0 wiring, identical to a wire:
//   master.req = slave.req, slave.gnt = master.gnt, and all payloads pass through;
//   master.lrdy = slave.lrdy, r_* pass through. No registers exist on that path.
// - Overflow: if master.r_valid = 1 while the response buffer is TWO, the response is dropped
//   and rsp_overflow_o sets to 1. It holds until clear_i. This applies only to targets that ignore lrdy.
// - idle_o = (req state == EMPTY) & (rsp state == EMPTY). A disabled path counts as empty.
// - clear_i (synchronous, dominates every other event):
//   state = EMPTY, payload registers = 0, rsp_overflow_o = 0.
//   Output values while clear_i = 1 and in the following cycle:
//   master.req = 0, slave.r_valid = 0, slave.gnt = 0 and master.lrdy = 0 while clear_i = 1, then 1, idle_o = 1.
// - clear_i mid-operation discards buffered entries without completing them. The system must
//   quiesce (idle_o = 1) before clear_i; the block does not replay discarded transactions.
// TESTING
// 1 Reset: clear_i = 1 for 2 cycles, then 0 -> master.req = 0, r_valid = 0, idle_o = 1; gnt and lrdy = 1 in the first cycle after release.
// 2 Streaming: 8 writes, add = 0x100 + 4*i, master.gnt = 1 always
//   -> master.req stream identical and in order, delayed 1 cycle; slave.gnt never 0.
// 3 Backpressure: master.gnt = 0 for 4 cycles during streaming
//   -> slave.gnt drops after 2 accepted requests; no request is lost or duplicated;
//   master payload stays stable while req = 1 and gnt = 0.
// 4 Simultaneous push and pop in ONE: alternate gnt 1/0 with slave.req = 1
//   -> state never exceeds TWO; order is preserved (compare against a scoreboard).
// 5 Response overflow: the target asserts r_valid for 3 cycles with slave.lrdy = 0
//   -> 2 responses are buffered and the 3rd is dropped; rsp_overflow_o = 1 until clear_i.
// 6 REQ_CUT = 0, RSP_CUT = 0 -> all outputs equal their inputs in the same cycle; idle_o = 1 constantly.

Source files
------------

// File: rtl/hci_core_pipe_slice.sv
// Registered HCI core slice: optional 2-entry skid buffers on the request and
// response directions, each falling back to a plain wire when its cut is disabled.

module hci_core_pipe_slice_skid #(
  parameter int unsigned PW = 8
) (
  input  logic          clk_i,
  input  logic          clear_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic          empty,
  output logic          full
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          wr_ptr_reg, rd_ptr_reg;
  logic          ready_reg;
  logic [PW-1:0] mem_reg [2];
  logic          push, pop;

  // ready_reg mirrors (state != TWO) one cycle ahead, so in_ready has no
  // combinational path from out_ready; clear_i forces it low while asserted.
  assign in_ready  = ready_reg & ~clear_i;
  assign out_valid = (state_reg != EMPTY) & ~clear_i;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_reg[rd_ptr_reg];
  assign empty     = (state_reg == EMPTY);
  assign full      = (state_reg == TWO);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = TWO;
        else if (pop && !push) state_next = EMPTY;
      end
      TWO:     if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_reg  <= EMPTY;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != TWO);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
    end else if (push) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
  end

endmodule

module hci_core_pipe_slice #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned BW      = 8,
  parameter int unsigned UW      = 1,
  parameter bit          REQ_CUT = 1'b1,
  parameter bit          RSP_CUT = 1'b1
) (
  input  logic               clk_i,
  input  logic               clear_i,
  // initiator side
  input  logic               tcdm_slave_req,
  output logic               tcdm_slave_gnt,
  input  logic [AW-1:0]      tcdm_slave_add,
  input  logic               tcdm_slave_wen,
  input  logic [DW-1:0]      tcdm_slave_data,
  input  logic [DW/BW-1:0]   tcdm_slave_be,
  input  logic [BW-1:0]      tcdm_slave_boffs,
  input  logic [UW-1:0]      tcdm_slave_user,
  input  logic               tcdm_slave_lrdy,
  output logic [DW-1:0]      tcdm_slave_r_data,
  output logic               tcdm_slave_r_valid,
  output logic               tcdm_slave_r_opc,
  output logic [UW-1:0]      tcdm_slave_r_user,
  // target side
  output logic               tcdm_master_req,
  input  logic               tcdm_master_gnt,
  output logic [AW-1:0]      tcdm_master_add,
  output logic               tcdm_master_wen,
  output logic [DW-1:0]      tcdm_master_data,
  output logic [DW/BW-1:0]   tcdm_master_be,
  output logic [BW-1:0]      tcdm_master_boffs,
  output logic [UW-1:0]      tcdm_master_user,
  output logic               tcdm_master_lrdy,
  input  logic [DW-1:0]      tcdm_master_r_data,
  input  logic               tcdm_master_r_valid,
  input  logic               tcdm_master_r_opc,
  input  logic [UW-1:0]      tcdm_master_r_user,
  output logic               idle_o,
  output logic               rsp_overflow_o
);

  localparam int unsigned BEW    = DW / BW;
  localparam int unsigned REQ_PW = AW + 1 + DW + BEW + BW + UW;
  localparam int unsigned RSP_PW = DW + 1 + UW;

  logic [REQ_PW-1:0] req_in, req_out;
  logic [RSP_PW-1:0] rsp_in, rsp_out;
  logic              req_empty, rsp_empty;
  logic              ovf_event;
  logic              ovf_reg;

  assign req_in = {tcdm_slave_add, tcdm_slave_wen, tcdm_slave_data,
                   tcdm_slave_be, tcdm_slave_boffs, tcdm_slave_user};
  assign {tcdm_master_add, tcdm_master_wen, tcdm_master_data,
          tcdm_master_be, tcdm_master_boffs, tcdm_master_user} = req_out;

  assign rsp_in = {tcdm_master_r_data, tcdm_master_r_opc, tcdm_master_r_user};
  assign {tcdm_slave_r_data, tcdm_slave_r_opc, tcdm_slave_r_user} = rsp_out;

  generate
    if (REQ_CUT) begin : g_req_cut
      logic req_full;
      hci_core_pipe_slice_skid #(.PW(REQ_PW)) i_req_skid (
        .clk_i     (clk_i),
        .clear_i   (clear_i),
        .in_valid  (tcdm_slave_req),
        .in_ready  (tcdm_slave_gnt),
        .in_data   (req_in),
        .out_valid (tcdm_master_req),
        .out_ready (tcdm_master_gnt),
        .out_data  (req_out),
        .empty     (req_empty),
        .full      (req_full)
      );
    end else begin : g_req_wire
      assign tcdm_master_req = tcdm_slave_req;
      assign tcdm_slave_gnt  = tcdm_master_gnt;
      assign req_out         = req_in;
      assign req_empty       = 1'b1;
    end

    if (RSP_CUT) begin : g_rsp_cut
      logic rsp_full;
      hci_core_pipe_slice_skid #(.PW(RSP_PW)) i_rsp_skid (
        .clk_i     (clk_i),
        .clear_i   (clear_i),
        .in_valid  (tcdm_master_r_valid),
        .in_ready  (tcdm_master_lrdy),
        .in_data   (rsp_in),
        .out_valid (tcdm_slave_r_valid),
        .out_ready (tcdm_slave_lrdy),
        .out_data  (rsp_out),
        .empty     (rsp_empty),
        .full      (rsp_full)
      );
      // A target that ignores lrdy can still push into a full buffer; that response is lost.
      assign ovf_event = tcdm_master_r_valid & rsp_full & ~clear_i;
    end else begin : g_rsp_wire
      assign tcdm_slave_r_valid = tcdm_master_r_valid;
      assign tcdm_master_lrdy   = tcdm_slave_lrdy;
      assign rsp_out            = rsp_in;
      assign rsp_empty          = 1'b1;
      assign ovf_event          = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (clear_i)        ovf_reg <= 1'b0;
    else if (ovf_event) ovf_reg <= 1'b1;
  end

  assign rsp_overflow_o = ovf_reg;
  assign idle_o         = req_empty & rsp_empty;

endmodule

// File: tb/tb_hci_core_pipe_slice.sv
// Directed bench for hci_core_pipe_slice: a cut instance checked cycle by cycle
// against a vector table, and a wire instance checked for same-cycle pass-through.

module tb_hci_core_pipe_slice;

  logic        clk = 1'b0;
  logic        clear;
  logic        s_req, s_wen, s_user, s_lrdy;
  logic [31:0] s_add, s_data;
  logic [3:0]  s_be;
  logic [7:0]  s_boffs;
  logic        m_gnt, m_r_valid, m_r_opc, m_r_user;
  logic [31:0] m_r_data;

  logic        d_s_gnt, d_s_r_valid, d_s_r_opc, d_s_r_user;
  logic [31:0] d_s_r_data, d_m_add, d_m_data;
  logic        d_m_req, d_m_wen, d_m_user, d_m_lrdy, d_idle, d_ovf;
  logic [3:0]  d_m_be;
  logic [7:0]  d_m_boffs;

  logic        w_s_gnt, w_s_r_valid, w_s_r_opc, w_s_r_user;
  logic [31:0] w_s_r_data, w_m_add, w_m_data;
  logic        w_m_req, w_m_wen, w_m_user, w_m_lrdy, w_idle, w_ovf;
  logic [3:0]  w_m_be;
  logic [7:0]  w_m_boffs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hci_core_pipe_slice #(.REQ_CUT(1'b1), .RSP_CUT(1'b1)) dut (
    .clk_i(clk), .clear_i(clear),
    .tcdm_slave_req(s_req), .tcdm_slave_gnt(d_s_gnt), .tcdm_slave_add(s_add),
    .tcdm_slave_wen(s_wen), .tcdm_slave_data(s_data), .tcdm_slave_be(s_be),
    .tcdm_slave_boffs(s_boffs), .tcdm_slave_user(s_user), .tcdm_slave_lrdy(s_lrdy),
    .tcdm_slave_r_data(d_s_r_data), .tcdm_slave_r_valid(d_s_r_valid),
    .tcdm_slave_r_opc(d_s_r_opc), .tcdm_slave_r_user(d_s_r_user),
    .tcdm_master_req(d_m_req), .tcdm_master_gnt(m_gnt), .tcdm_master_add(d_m_add),
    .tcdm_master_wen(d_m_wen), .tcdm_master_data(d_m_data), .tcdm_master_be(d_m_be),
    .tcdm_master_boffs(d_m_boffs), .tcdm_master_user(d_m_user), .tcdm_master_lrdy(d_m_lrdy),
    .tcdm_master_r_data(m_r_data), .tcdm_master_r_valid(m_r_valid),
    .tcdm_master_r_opc(m_r_opc), .tcdm_master_r_user(m_r_user),
    .idle_o(d_idle), .rsp_overflow_o(d_ovf)
  );

  hci_core_pipe_slice #(.REQ_CUT(1'b0), .RSP_CUT(1'b0)) dut_wire (
    .clk_i(clk), .clear_i(clear),
    .tcdm_slave_req(s_req), .tcdm_slave_gnt(w_s_gnt), .tcdm_slave_add(s_add),
    .tcdm_slave_wen(s_wen), .tcdm_slave_data(s_data), .tcdm_slave_be(s_be),
    .tcdm_slave_boffs(s_boffs), .tcdm_slave_user(s_user), .tcdm_slave_lrdy(s_lrdy),
    .tcdm_slave_r_data(w_s_r_data), .tcdm_slave_r_valid(w_s_r_valid),
    .tcdm_slave_r_opc(w_s_r_opc), .tcdm_slave_r_user(w_s_r_user),
    .tcdm_master_req(w_m_req), .tcdm_master_gnt(m_gnt), .tcdm_master_add(w_m_add),
    .tcdm_master_wen(w_m_wen), .tcdm_master_data(w_m_data), .tcdm_master_be(w_m_be),
    .tcdm_master_boffs(w_m_boffs), .tcdm_master_user(w_m_user), .tcdm_master_lrdy(w_m_lrdy),
    .tcdm_master_r_data(m_r_data), .tcdm_master_r_valid(m_r_valid),
    .tcdm_master_r_opc(m_r_opc), .tcdm_master_r_user(m_r_user),
    .idle_o(w_idle), .rsp_overflow_o(w_ovf)
  );

  typedef struct {
    logic        s_req;
    logic [31:0] add;
    logic        m_gnt;
    logic        exp_s_gnt;
    logic        exp_m_req;
    logic [31:0] exp_add;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  // Full request payload derived from the address so every field is exercised.
  function automatic logic [77:0] req_pl(input logic [31:0] a);
    return {a, a[2], a[15:0], ~a[15:0], a[5:2], a[7:0], a[3]};
  endfunction

  function automatic logic [33:0] rsp_pl(input logic [31:0] d);
    return {d, d[0], d[1]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_v(input logic sr, input logic [31:0] a, input logic g,
                       input logic esg, input logic emr, input logic [31:0] ea);
    vecs.push_back('{s_req: sr, add: a, m_gnt: g, exp_s_gnt: esg, exp_m_req: emr, exp_add: ea});
  endtask

  task automatic rsp_step(input logic rv, input logic [31:0] d, input logic lrdy,
                          input logic e_lrdy, input logic e_rv, input logic [31:0] e_d,
                          input logic e_ovf, input logic e_idle);
    @(negedge clk);
    m_r_valid = rv;
    {m_r_data, m_r_opc, m_r_user} = rsp_pl(d);
    s_lrdy = lrdy;
    #1;
    chk("rsp_m_lrdy", d_m_lrdy, e_lrdy);
    chk("rsp_s_r_valid", d_s_r_valid, e_rv);
    if (e_rv) chk("rsp_payload", {d_s_r_data, d_s_r_opc, d_s_r_user}, rsp_pl(e_d));
    chk("rsp_overflow", d_ovf, e_ovf);
    chk("rsp_idle", d_idle, e_idle);
    chk("wire_r_valid", w_s_r_valid, rv);
    chk("wire_r_payload", {w_s_r_data, w_s_r_opc, w_s_r_user}, rsp_pl(d));
    chk("wire_lrdy", w_m_lrdy, lrdy);
    $display("rsp r_valid=%0b r_data=%08h lrdy=%0b -> s_r_valid=%0b s_r_data=%08h ovf=%0b",
             rv, d, lrdy, d_s_r_valid, d_s_r_data, d_ovf);
  endtask

  initial begin
    clear = 1'b1; s_req = 0; s_add = 0; s_wen = 0; s_data = 0; s_be = 0; s_boffs = 0;
    s_user = 0; s_lrdy = 1; m_gnt = 1; m_r_valid = 0; m_r_data = 0; m_r_opc = 0; m_r_user = 0;

    // Streaming: 8 writes, one-cycle latency, gnt never drops
    add_v(1, 32'h100, 1, 1, 0, 32'h0);
    for (int i = 1; i < 8; i++)
      add_v(1, 32'h100 + 32'(4 * i), 1, 1, 1, 32'h100 + 32'(4 * (i - 1)));
    add_v(0, 32'h0, 1, 1, 1, 32'h11C);
    add_v(0, 32'h0, 1, 1, 0, 32'h0);
    // Backpressure: gnt low for 4 cycles, slave.gnt drops after two accepts
    add_v(1, 32'h200, 1, 1, 0, 32'h0);
    add_v(1, 32'h204, 0, 1, 1, 32'h200);
    add_v(1, 32'h208, 0, 0, 1, 32'h200);
    add_v(1, 32'h208, 0, 0, 1, 32'h200);
    add_v(1, 32'h208, 0, 0, 1, 32'h200);
    add_v(1, 32'h208, 1, 0, 1, 32'h200);
    add_v(1, 32'h208, 1, 1, 1, 32'h204);
    add_v(1, 32'h20C, 1, 1, 1, 32'h208);
    add_v(0, 32'h0,   1, 1, 1, 32'h20C);
    add_v(0, 32'h0,   1, 1, 0, 32'h0);
    // Alternating gnt with req held high
    add_v(1, 32'h300, 1, 1, 0, 32'h0);
    add_v(1, 32'h304, 0, 1, 1, 32'h300);
    add_v(1, 32'h308, 1, 0, 1, 32'h300);
    add_v(1, 32'h308, 0, 1, 1, 32'h304);
    add_v(1, 32'h30C, 1, 0, 1, 32'h304);
    add_v(1, 32'h30C, 0, 1, 1, 32'h308);
    add_v(1, 32'h310, 1, 0, 1, 32'h308);
    add_v(0, 32'h0,   1, 1, 1, 32'h30C);
    add_v(0, 32'h0,   1, 1, 0, 32'h0);

    // Reset: two cycles of clear
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("clr_m_req", d_m_req, 1'b0);
    chk("clr_r_valid", d_s_r_valid, 1'b0);
    chk("clr_s_gnt", d_s_gnt, 1'b0);
    chk("clr_m_lrdy", d_m_lrdy, 1'b0);
    clear = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_m_req", d_m_req, 1'b0);
    chk("rst_r_valid", d_s_r_valid, 1'b0);
    chk("rst_s_gnt", d_s_gnt, 1'b1);
    chk("rst_m_lrdy", d_m_lrdy, 1'b1);
    chk("rst_idle", d_idle, 1'b1);
    chk("rst_ovf", d_ovf, 1'b0);
    $display("reset released: gnt=%0b lrdy=%0b idle=%0b", d_s_gnt, d_m_lrdy, d_idle);

    foreach (vecs[i]) begin
      @(negedge clk);
      s_req = vecs[i].s_req;
      {s_add, s_wen, s_data, s_be, s_boffs, s_user} = req_pl(vecs[i].add);
      m_gnt = vecs[i].m_gnt;
      #1;
      chk("s_gnt", d_s_gnt, vecs[i].exp_s_gnt);
      chk("m_req", d_m_req, vecs[i].exp_m_req);
      if (vecs[i].exp_m_req)
        chk("m_payload", {d_m_add, d_m_wen, d_m_data, d_m_be, d_m_boffs, d_m_user},
            req_pl(vecs[i].exp_add));
      chk("idle", d_idle, !vecs[i].exp_m_req);
      chk("wire_req", w_m_req, vecs[i].s_req);
      chk("wire_gnt", w_s_gnt, vecs[i].m_gnt);
      chk("wire_payload", {w_m_add, w_m_wen, w_m_data, w_m_be, w_m_boffs, w_m_user},
          req_pl(vecs[i].add));
      chk("wire_idle", w_idle, 1'b1);
      if (s_req && d_s_gnt) sb.push_back(s_add);
      if (d_m_req && m_gnt) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_order: got %08h expected nothing outstanding", d_m_add);
        end else begin
          chk("sb_order", d_m_add, sb.pop_front());
        end
      end
      $display("req %0d: s_req=%0b add=%08h gnt_in=%0b -> s_gnt=%0b m_req=%0b m_add=%08h",
               i, vecs[i].s_req, vecs[i].add, vecs[i].m_gnt, d_s_gnt, d_m_req, d_m_add);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Response overflow: r_valid for 3 cycles with lrdy low, third response dropped
    rsp_step(1, 32'hAAAA0001, 0, 1, 0, 32'h0,        0, 1);
    rsp_step(1, 32'hBBBB0002, 0, 1, 1, 32'hAAAA0001, 0, 0);
    rsp_step(1, 32'hCCCC0003, 0, 0, 1, 32'hAAAA0001, 0, 0);
    rsp_step(0, 32'h0,        1, 0, 1, 32'hAAAA0001, 1, 0);
    rsp_step(0, 32'h0,        1, 1, 1, 32'hBBBB0002, 1, 0);
    rsp_step(0, 32'h0,        1, 1, 0, 32'h0,        1, 1);

    // Clear while a request is parked in the buffer
    @(negedge clk);
    s_req = 1'b1;
    {s_add, s_wen, s_data, s_be, s_boffs, s_user} = req_pl(32'h400);
    m_gnt = 1'b0;
    @(negedge clk);
    s_req = 1'b0;
    clear = 1'b1;
    #1;
    chk("mid_clr_m_req", d_m_req, 1'b0);
    chk("mid_clr_s_gnt", d_s_gnt, 1'b0);
    chk("mid_clr_m_lrdy", d_m_lrdy, 1'b0);
    chk("mid_clr_ovf_held", d_ovf, 1'b1);
    @(negedge clk);
    clear = 1'b0;
    m_gnt = 1'b1;
    #1;
    chk("post_clr_ovf", d_ovf, 1'b0);
    chk("post_clr_m_req", d_m_req, 1'b0);
    chk("post_clr_s_gnt", d_s_gnt, 1'b1);
    chk("post_clr_m_lrdy", d_m_lrdy, 1'b1);
    chk("post_clr_idle", d_idle, 1'b1);
    $display("clear: ovf=%0b idle=%0b m_req=%0b", d_ovf, d_idle, d_m_req);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
